// File: rtl/pipe_alu.sv
// Pipelined ALU: single-cycle ops finish in one cycle, multiply-class ops take
// MUL_LAT cycles and hold the unit busy in EXEC while they run.
module pipe_alu #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [3:0]           op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 zero_o,
    output logic                 err_o
);
    localparam int W2 = 2 * WIDTH;
    localparam logic IDLE = 1'b0;
    localparam logic EXEC = 1'b1;
    localparam logic MULTI_EN = (MUL_LAT > 1);
    // EXEC ends on the edge where the counter steps from MUL_LAT-2 to MUL_LAT-1.
    localparam logic [3:0] LAST_EXEC = 4'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);

    logic               state_reg;
    logic [3:0]         cnt_reg;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               done_reg;
    logic [W2-1:0]      result_reg;
    logic               zero_reg;
    logic               err_reg;

    logic [3:0]         op_sel;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [W2-1:0]      sa;
    logic [W2-1:0]      sb;
    logic [W2-1:0]      alu_res;
    logic               alu_illegal;
    logic               is_multi;

    // One shared datapath: live inputs in IDLE, captured operands in EXEC.
    assign op_sel = (state_reg == EXEC) ? op_reg : op_i;
    assign a_sel  = (state_reg == EXEC) ? a_reg  : a_i;
    assign b_sel  = (state_reg == EXEC) ? b_reg  : b_i;
    assign sa     = {{WIDTH{1'b0}}, a_sel};
    assign sb     = {{WIDTH{1'b0}}, b_sel};
    assign is_multi = (op_i == 4'd4) || (op_i >= 4'd7 && op_i <= 4'd10);

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (op_sel)
            4'd0:    alu_res = '0;
            4'd1:    alu_res = sa + sb;
            4'd2:    alu_res = sa & sb;
            4'd3:    alu_res = sa - sb;
            4'd4:    alu_res = sa * sb;
            4'd5:    alu_res = {a_sel, b_sel} >> 1;
            4'd6:    alu_res = {a_sel, b_sel} << 1;
            4'd7:    alu_res = (sa * sb) - sa;
            4'd8:    alu_res = ((sa * sb) << 2) - sa;
            4'd9:    alu_res = (sa * sb) + sa;
            4'd10:   alu_res = (sa << 1) + sa;
            4'd11:   alu_res = sa ^ sb;
            4'd12:   alu_res = sa | sb;
            4'd13:   alu_res = {{WIDTH{1'b0}}, ~(a_sel ^ b_sel)};
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        cnt_reg <= '0;
                        if (is_multi && MULTI_EN) begin
                            state_reg <= EXEC;
                            op_reg    <= op_i;
                            a_reg     <= a_i;
                            b_reg     <= b_i;
                        end else begin
                            done_reg   <= 1'b1;
                            result_reg <= alu_res;
                            zero_reg   <= (alu_res == '0);
                            err_reg    <= alu_illegal;
                        end
                    end
                end
                default: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == LAST_EXEC) begin
                        state_reg  <= IDLE;
                        done_reg   <= 1'b1;
                        result_reg <= alu_res;
                        zero_reg   <= (alu_res == '0);
                        err_reg    <= alu_illegal;
                    end
                end
            endcase
        end
    end

    assign ready_o  = (state_reg == IDLE);
    assign done_o   = done_reg;
    assign result_o = result_reg;
    assign zero_o   = zero_reg;
    assign err_o    = err_reg;
endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu (WIDTH=8, MUL_LAT=3): expected results and
// completion cycles are queued at issue and compared when done_o appears.
module tb_pipe_alu;
    typedef struct {
        logic [17:0] val;   // {err, zero, result}
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [3:0]  op_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        ready_o;
    logic        done_o;
    logic [15:0] result_o;
    logic        zero_o;
    logic        err_o;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    exp_t sb_q[$];
    logic [17:0] last_val = '0;

    pipe_alu #(.WIDTH(8), .MUL_LAT(3)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .ready_o(ready_o), .done_o(done_o),
        .result_o(result_o), .zero_o(zero_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [17:0] model(input int op, input int a, input int b);
        int r;
        bit e;
        e = 1'b0;
        case (op)
            0:  r = 0;
            1:  r = a + b;
            2:  r = a & b;
            3:  r = a - b;
            4:  r = a * b;
            5:  r = (a * 256 + b) / 2;
            6:  r = (a * 256 + b) * 2;
            7:  r = a * b - a;
            8:  r = 4 * a * b - a;
            9:  r = a * b + a;
            10: r = 3 * a;
            11: r = a ^ b;
            12: r = a | b;
            13: r = (~(a ^ b)) & 255;
            default: begin r = 0; e = 1'b1; end
        endcase
        r = r & 32'hFFFF;
        return {e, (r == 0), r[15:0]};
    endfunction

    function automatic int lat_of(input int op);
        return (op == 4 || (op >= 7 && op <= 10)) ? 3 : 1;
    endfunction

    // Monitor samples 1ns after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            check("rst_result", {14'd0, err_o, zero_o, result_o}, 32'd0);
            check("rst_done", {31'd0, done_o}, 32'd0);
            check("rst_ready", {31'd0, ready_o}, 32'd1);
            last_val = '0;
        end else if (done_o) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", {16'd0, result_o}, {16'd0, e.val[15:0]});
                check("zero", {31'd0, zero_o}, {31'd0, e.val[16]});
                check("err", {31'd0, err_o}, {31'd0, e.val[17]});
                check("latency", cyc, e.cyc);
                last_val = e.val;
            end
        end else begin
            check("hold", {14'd0, err_o, zero_o, result_o}, {14'd0, last_val});
        end
    end

    // Called at a falling edge; returns one falling edge later with inputs scrambled.
    task automatic issue(input int op, input int a, input int b);
        exp_t e;
        check("ready_at_issue", {31'd0, ready_o}, 32'd1);
        start_i = 1'b1;
        op_i = 4'(op);
        a_i = 8'(a);
        b_i = 8'(b);
        e.val = model(op, a, b);
        e.cyc = cyc + lat_of(op);
        sb_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        op_i = 4'($urandom_range(0, 15));
        a_i = 8'($urandom);
        b_i = 8'($urandom);
    endtask

    task automatic run_op(input int op, input int a, input int b);
        issue(op, a, b);
        repeat (lat_of(op) - 1) @(negedge clk);
    endtask

    initial begin
        int wait_cyc;
        rst = 1'b1;
        start_i = 1'b1;      // ignored while in reset
        op_i = 4'd1;
        a_i = 8'd1;
        b_i = 8'd1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;

        run_op(1, 200, 100);
        // MUL with an ignored ADD during EXEC, then ADD in the done cycle.
        issue(4, 255, 255);
        check("busy_exec1", {31'd0, ready_o}, 32'd0);
        start_i = 1'b1; op_i = 4'd1; a_i = 8'd1; b_i = 8'd1;
        @(negedge clk);
        check("busy_exec2", {31'd0, ready_o}, 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        run_op(1, 1, 1);
        run_op(8, 3, 5);
        run_op(3, 5, 7);
        run_op(13, 8'hF0, 8'h0F);
        run_op(15, 9, 9);
        run_op(2, 8'hAA, 8'h0F);

        // Reset during the second EXEC cycle aborts the MUL.
        issue(4, 12, 34);
        @(negedge clk);
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_abort", {31'd0, done_o}, 32'd0);
        end

        for (int op = 0; op < 16; op++) run_op(op, $urandom_range(0, 255), $urandom_range(0, 255));
        for (int i = 0; i < 24; i++) run_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        run_op(6, 8'h80, 8'h01);
        run_op(5, 8'h01, 8'h01);

        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("drain", sb_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
